// File: rtl/beta_trace_buffer_if.sv
// CPU write-back strobes and host MAU readout port for the Beta trace buffer.
// The master side is the CPU/host; the slave side is the capture block.
interface beta_trace_buffer_if #(
    parameter int DATA_W = 32
);
    logic              exported_wren_rfw;
    logic [DATA_W-1:0] exported_address_rfw;
    logic [DATA_W-1:0] exported_data_rfw;
    logic              exported_wren_dm;
    logic [DATA_W-1:0] exported_address_dm;
    logic [DATA_W-1:0] exported_data_dm;
    logic [31:0]       mau_address_tb;
    logic [DATA_W-1:0] mau_read_data_tb;

    modport master (
        output exported_wren_rfw, exported_address_rfw, exported_data_rfw,
        output exported_wren_dm, exported_address_dm, exported_data_dm,
        output mau_address_tb,
        input  mau_read_data_tb
    );

    modport slave (
        input  exported_wren_rfw, exported_address_rfw, exported_data_rfw,
        input  exported_wren_dm, exported_address_dm, exported_data_dm,
        input  mau_address_tb,
        output mau_read_data_tb
    );
endinterface

// File: rtl/beta_trace_buffer.sv
// Timestamped capture of Beta register-file / data-memory writes into a DEPTH-deep
// buffer, with stop-on-full (halt) or circular overwrite, read back over a MAU port.
module beta_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alive,
    input  logic                 mode,
    input  logic                 clear,
    output logic                 halt,
    output logic [IW:0]          count,
    output logic                 overflow,
    beta_trace_buffer_if.slave   bus
);

    typedef struct packed {
        logic              wren_dm;
        logic              wren_rfw;
        logic [DATA_W-1:0] addr_rfw;
        logic [DATA_W-1:0] data_rfw;
        logic [DATA_W-1:0] addr_dm;
        logic [DATA_W-1:0] data_dm;
        logic [TS_W-1:0]   ts;
    } entry_t;

    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [IW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic          event_w, full, wr_en;
    logic [2:0]    sel;
    logic [IW-1:0] idx, slot;
    logic          hit;
    entry_t        rd_ent, wr_ent;
    logic          unused_addr_bits;

    assign event_w = alive & (bus.exported_wren_rfw | bus.exported_wren_dm);
    assign full    = (count_q == FULL);
    // When full the oldest slot coincides with wr_ptr, so overwrite also writes there.
    assign wr_en   = event_w & ~clear & (~full | mode);

    assign halt     = full & ~mode;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign bus.mau_read_data_tb = rd_q;

    assign wr_ent = '{
        wren_dm:  bus.exported_wren_dm,
        wren_rfw: bus.exported_wren_rfw,
        addr_rfw: bus.exported_address_rfw,
        data_rfw: bus.exported_data_rfw,
        addr_dm:  bus.exported_address_dm,
        data_dm:  bus.exported_data_dm,
        ts:       ts_q
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ts_d     = ts_q + TS_W'(1);
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            ts_d     = '0;
        end else if (event_w) begin
            if (!full) begin
                wr_ptr_d = wr_ptr_q + IW'(1);
                count_d  = count_q + (IW+1)'(1);
            end else begin
                ovf_d = 1'b1;
                if (mode) wr_ptr_d = wr_ptr_q + IW'(1);
            end
        end
    end

    // Readout resolves the relative index against the pre-edge oldest pointer.
    assign sel    = bus.mau_address_tb[2:0];
    assign idx    = bus.mau_address_tb[IW+2:3];
    assign slot   = wr_ptr_q - count_q[IW-1:0] + idx;
    assign hit    = ({1'b0, idx} < count_q);
    assign rd_ent = mem_q[slot];
    assign unused_addr_bits = ^bus.mau_address_tb[31:IW+3];

    always_comb begin
        rd_d = '0;
        case (sel)
            3'd0: rd_d = DATA_W'({rd_ent.wren_dm, rd_ent.wren_rfw});
            3'd1: rd_d = rd_ent.addr_rfw;
            3'd2: rd_d = rd_ent.data_rfw;
            3'd3: rd_d = rd_ent.addr_dm;
            3'd4: rd_d = rd_ent.data_dm;
            3'd5: rd_d = DATA_W'(rd_ent.ts);
            3'd6: rd_d = DATA_W'({ovf_q, halt, count_q});
            default: rd_d = '0;
        endcase
        if (sel < 3'd6 && !hit) rd_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ts_q     <= '0;
            rd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ts_q     <= ts_d;
            rd_q     <= rd_d;
        end
    end

    // Storage needs no reset: count masks stale slots.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
    end

endmodule
